// File: rtl/time_adj_pkg.sv
// Shared types and default timing constants for the time-adjust key controller.
package time_adj_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_ADJ_IDLE   = 2'd1,
        ST_ADJ_DELAY  = 2'd2,
        ST_ADJ_REPEAT = 2'd3
    } adj_state_e;

    localparam int unsigned DEF_REPEAT_DLY = 50_000_000;
    localparam int unsigned DEF_REPEAT_PER = 10_000_000;
    localparam int unsigned DEF_TIMEOUT    = 500_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        max_u = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Hold-to-repeat timer: one tick after REPEAT_DLY held cycles, then one every REPEAT_PER.
module key_repeat_timer
    import time_adj_pkg::*;
#(
    parameter int unsigned REPEAT_DLY = DEF_REPEAT_DLY,
    parameter int unsigned REPEAT_PER = DEF_REPEAT_PER
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam int unsigned CW = $clog2(max_u(REPEAT_DLY, REPEAT_PER) + 1);

    logic [CW-1:0] cnt_q;
    logic          rep_q;
    logic [CW-1:0] limit;

    // rep_q selects which interval is being timed: initial delay or repeat period.
    assign limit  = rep_q ? CW'(REPEAT_PER - 1) : CW'(REPEAT_DLY - 1);
    assign tick_o = hold_i && !start_i && (cnt_q >= limit);

    always_ff @(posedge clk_i) begin
        if (rst_i || start_i || !hold_i) begin
            cnt_q <= '0;
            rep_q <= 1'b0;
        end else if (tick_o) begin
            cnt_q <= '0;
            rep_q <= 1'b1;
        end else if (cnt_q != {CW{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/time_adjust_ctrl.sv
// Clock time-adjust controller: field selection, single-step and auto-repeat pulses, idle timeout.
module time_adjust_ctrl
    import time_adj_pkg::*;
#(
    parameter int unsigned NUM_FIELDS = 3,
    parameter int unsigned REPEAT_DLY = DEF_REPEAT_DLY,
    parameter int unsigned REPEAT_PER = DEF_REPEAT_PER,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  key_adjust_flag,
    input  logic                  key_add_flag,
    input  logic                  key_sub_flag,
    input  logic                  key_add_hold,
    input  logic                  key_sub_hold,
    output logic [NUM_FIELDS-1:0] field_en,
    output logic [NUM_FIELDS-1:0] field_add,
    output logic [NUM_FIELDS-1:0] field_sub,
    output logic                  adjusting
);

    localparam int unsigned    FW        = $clog2(NUM_FIELDS);
    localparam int unsigned    TW        = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0]  LAST_FIDX = FW'(NUM_FIELDS - 1);

    adj_state_e            state_q;
    logic [FW-1:0]         fidx_q;
    logic                  dir_sub_q;
    logic [NUM_FIELDS-1:0] field_en_q;
    logic [NUM_FIELDS-1:0] field_add_q;
    logic [NUM_FIELDS-1:0] field_sub_q;
    logic [TW-1:0]         to_q;

    logic in_adj;
    logic any_key;
    logic add_only;
    logic sub_only;
    logic hold_match;
    logic to_hit;
    logic tmr_start;
    logic tmr_run;
    logic tmr_tick;

    // Field 0 is the most significant field, so it maps to the top bit.
    function automatic logic [NUM_FIELDS-1:0] sel_mask(input logic [FW-1:0] idx);
        sel_mask = '0;
        sel_mask[LAST_FIDX - idx] = 1'b1;
    endfunction

    assign in_adj     = (state_q != ST_RUN);
    assign any_key    = key_adjust_flag | key_add_flag | key_sub_flag | key_add_hold | key_sub_hold;
    assign add_only   = key_add_flag & ~key_sub_flag;
    assign sub_only   = key_sub_flag & ~key_add_flag;
    assign hold_match = dir_sub_q ? key_sub_hold : key_add_hold;
    assign to_hit     = in_adj && !any_key && (to_q >= TW'(TIMEOUT - 1));
    assign tmr_start  = (state_q == ST_ADJ_IDLE) && !key_adjust_flag && (add_only || sub_only);
    assign tmr_run    = hold_match && ((state_q == ST_ADJ_DELAY) || (state_q == ST_ADJ_REPEAT));

    key_repeat_timer #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_timer (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .start_i (tmr_start),
        .hold_i  (tmr_run),
        .tick_o  (tmr_tick)
    );

    // Idle counter: any key activity or leaving adjust mode restarts it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !in_adj || any_key) begin
            to_q <= '0;
        end else if (to_q != TW'(TIMEOUT)) begin
            to_q <= to_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= ST_RUN;
            fidx_q      <= '0;
            dir_sub_q   <= 1'b0;
            field_en_q  <= '0;
            field_add_q <= '0;
            field_sub_q <= '0;
        end else begin
            field_add_q <= '0;
            field_sub_q <= '0;
            case (state_q)
                ST_RUN: begin
                    if (key_adjust_flag) begin
                        state_q    <= ST_ADJ_IDLE;
                        fidx_q     <= '0;
                        field_en_q <= sel_mask('0);
                    end
                end
                default: begin
                    if (key_adjust_flag) begin
                        if (fidx_q != LAST_FIDX) begin
                            state_q    <= ST_ADJ_IDLE;
                            fidx_q     <= fidx_q + 1'b1;
                            field_en_q <= sel_mask(fidx_q + 1'b1);
                        end else begin
                            state_q    <= ST_RUN;
                            fidx_q     <= '0;
                            field_en_q <= '0;
                        end
                    end else if (to_hit) begin
                        state_q    <= ST_RUN;
                        fidx_q     <= '0;
                        field_en_q <= '0;
                    end else begin
                        case (state_q)
                            ST_ADJ_IDLE: begin
                                if (add_only || sub_only) begin
                                    dir_sub_q <= sub_only;
                                    state_q   <= ST_ADJ_DELAY;
                                    if (sub_only) field_sub_q <= field_en_q;
                                    else          field_add_q <= field_en_q;
                                end
                            end
                            ST_ADJ_DELAY: begin
                                if (!hold_match)   state_q <= ST_ADJ_IDLE;
                                else if (tmr_tick) state_q <= ST_ADJ_REPEAT;
                            end
                            ST_ADJ_REPEAT: begin
                                if (!hold_match) begin
                                    state_q <= ST_ADJ_IDLE;
                                end else if (tmr_tick) begin
                                    if (dir_sub_q) field_sub_q <= field_en_q;
                                    else           field_add_q <= field_en_q;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign field_en  = field_en_q;
    assign field_add = field_add_q;
    assign field_sub = field_sub_q;
    assign adjusting = |field_en_q;

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Self-checking bench for time_adjust_ctrl with short timing parameters.
module tb_time_adjust_ctrl;

    localparam int unsigned NF = 3;

    logic          sys_clk;
    logic          sys_rst;
    logic          key_adjust_flag;
    logic          key_add_flag;
    logic          key_sub_flag;
    logic          key_add_hold;
    logic          key_sub_hold;
    logic [NF-1:0] field_en;
    logic [NF-1:0] field_add;
    logic [NF-1:0] field_sub;
    logic          adjusting;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Expected pulse entries: {cycle, field_sub, field_add}.
    logic [37:0] exp_q[$];

    time_adjust_ctrl #(
        .NUM_FIELDS (NF),
        .REPEAT_DLY (8),
        .REPEAT_PER (4),
        .TIMEOUT    (32)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .key_adjust_flag (key_adjust_flag),
        .key_add_flag    (key_add_flag),
        .key_sub_flag    (key_sub_flag),
        .key_add_hold    (key_add_hold),
        .key_sub_hold    (key_sub_hold),
        .field_en        (field_en),
        .field_add       (field_add),
        .field_sub       (field_sub),
        .adjusting       (adjusting)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic push_exp(input int at, input logic [2:0] sub, input logic [2:0] add);
        exp_q.push_back({32'(at), sub, add});
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
    endtask

    task automatic press_adjust();
        key_adjust_flag = 1'b1;
        tick(1);
        key_adjust_flag = 1'b0;
    endtask

    // Pulse monitor: every nonzero add/sub output must match the next expected entry.
    always @(negedge sys_clk) begin
        if ((field_add | field_sub) != '0) begin
            if (exp_q.size() == 0)
                check("unexpected_pulse", {32'(cyc), field_sub, field_add}, 64'd0);
            else
                check("pulse", {32'(cyc), field_sub, field_add}, exp_q.pop_front());
        end
    end

    initial begin
        int c;
        logic [2:0] en_tab [4];
        logic       adj_tab[4];
        en_tab  = '{3'b100, 3'b010, 3'b001, 3'b000};
        adj_tab = '{1'b1, 1'b1, 1'b1, 1'b0};

        sys_rst = 1'b1;
        key_adjust_flag = 1'b0;
        key_add_flag = 1'b0;
        key_sub_flag = 1'b0;
        key_add_hold = 1'b0;
        key_sub_hold = 1'b0;
        tick(3);
        check("rst_en", field_en, 3'b000);
        check("rst_add", field_add, 3'b000);
        check("rst_sub", field_sub, 3'b000);
        check("rst_adjusting", adjusting, 1'b0);
        sys_rst = 1'b0;
        tick(1);

        // Keys other than adjust do nothing in RUN.
        key_add_flag = 1'b1;
        tick(1);
        key_add_flag = 1'b0;
        key_sub_flag = 1'b1;
        key_add_hold = 1'b1;
        key_sub_hold = 1'b1;
        tick(1);
        key_sub_flag = 1'b0;
        tick(3);
        key_add_hold = 1'b0;
        key_sub_hold = 1'b0;
        check("run_keys_en", field_en, 3'b000);
        check("run_keys_adjusting", adjusting, 1'b0);

        // Mode cycling.
        for (int i = 0; i < 4; i++) begin
            press_adjust();
            check($sformatf("cycle_en%0d", i), field_en, en_tab[i]);
            check($sformatf("cycle_adj%0d", i), adjusting, adj_tab[i]);
        end

        // Single add in field 1, hold low.
        do_reset();
        press_adjust();
        press_adjust();
        check("f1_en", field_en, 3'b010);
        c = cyc;
        push_exp(c + 1, 3'b000, 3'b010);
        key_add_flag = 1'b1;
        tick(1);
        key_add_flag = 1'b0;
        check("single_add", field_add, 3'b010);
        check("single_add_sub", field_sub, 3'b000);
        tick(1);
        check("single_add_end", field_add, 3'b000);
        tick(4);

        // Auto-repeat of sub in field 0; opposite keys ignored meanwhile.
        do_reset();
        press_adjust();
        c = cyc;
        foreach (en_tab[k]) if (k == 0) push_exp(c + 1, 3'b100, 3'b000);
        for (int k = 13; k <= 29; k += 4) push_exp(c + k, 3'b100, 3'b000);
        key_sub_flag = 1'b1;
        key_sub_hold = 1'b1;
        tick(1);
        key_sub_flag = 1'b0;
        tick(4);
        key_add_flag = 1'b1;
        tick(1);
        key_add_flag = 1'b0;
        key_add_hold = 1'b1;
        tick(4);
        key_add_hold = 1'b0;
        tick(20);
        key_sub_hold = 1'b0;
        check("repeat_en", field_en, 3'b100);
        tick(12);
        check("repeat_done_en", field_en, 3'b100);

        // Timeout in field 2.
        do_reset();
        press_adjust();
        press_adjust();
        press_adjust();
        tick(31);
        check("to_before", field_en, 3'b001);
        tick(1);
        check("to_expired_en", field_en, 3'b000);
        check("to_expired_adj", adjusting, 1'b0);

        // Hold activity in the 31st idle cycle restarts the count.
        do_reset();
        press_adjust();
        press_adjust();
        press_adjust();
        tick(30);
        key_add_hold = 1'b1;
        tick(1);
        key_add_hold = 1'b0;
        tick(1);
        check("to_restart_hold", field_en, 3'b001);
        tick(30);
        check("to_restart_before", field_en, 3'b001);
        tick(1);
        check("to_restart_expired", field_en, 3'b000);

        // Conflicting flags.
        do_reset();
        press_adjust();
        key_add_flag = 1'b1;
        key_sub_flag = 1'b1;
        tick(1);
        key_add_flag = 1'b0;
        key_sub_flag = 1'b0;
        tick(3);
        check("conf_addsub_en", field_en, 3'b100);
        key_adjust_flag = 1'b1;
        key_add_flag = 1'b1;
        tick(1);
        key_adjust_flag = 1'b0;
        key_add_flag = 1'b0;
        check("conf_adj_en", field_en, 3'b010);
        check("conf_adj_add", field_add, 3'b000);
        tick(1);
        check("conf_adj_add_late", field_add, 3'b000);
        c = cyc;
        push_exp(c + 1, 3'b000, 3'b010);
        key_add_flag = 1'b1;
        tick(1);
        key_add_flag = 1'b0;
        tick(3);

        // Reset during repeat, in the cycle that would register a pulse.
        do_reset();
        press_adjust();
        c = cyc;
        push_exp(c + 1, 3'b000, 3'b100);
        push_exp(c + 13, 3'b000, 3'b100);
        push_exp(c + 17, 3'b000, 3'b100);
        key_add_flag = 1'b1;
        key_add_hold = 1'b1;
        tick(1);
        key_add_flag = 1'b0;
        tick(19);
        sys_rst = 1'b1;
        tick(1);
        check("mid_rst_en", field_en, 3'b000);
        check("mid_rst_add", field_add, 3'b000);
        check("mid_rst_sub", field_sub, 3'b000);
        check("mid_rst_adj", adjusting, 1'b0);
        sys_rst = 1'b0;
        tick(12);
        key_add_hold = 1'b0;
        check("post_rst_en", field_en, 3'b000);
        tick(4);

        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/time_adjust_ctrl.md
TIME_ADJUST_CTRL -- requirements
Module: time_adjust_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  - NUM_FIELDS, 3, number of adjustable time fields, minimum 2.
  - REPEAT_DLY, 50_000_000, hold cycles before auto-repeat starts.
  - REPEAT_PER, 10_000_000, cycles between auto-repeat pulses.
  - TIMEOUT, 500_000_000, idle cycles before adjust mode is abandoned.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - sys_clk, in, 1, sole clock; one clock, all logic on its rising edge.
  - sys_rst, in, 1, reset, synchronous and active-high.
  - key_adjust_flag, in, 1, single-cycle pulse from a debounced key.
  - key_add_flag, in, 1, single-cycle pulse from a debounced key.
  - key_sub_flag, in, 1, single-cycle pulse from a debounced key.
  - key_add_hold, in, 1, debounced level, high while add is held.
  - key_sub_hold, in, 1, debounced level, high while sub is held.
  - field_en, out, NUM_FIELDS, one-hot selected field, bit NUM_FIELDS-1 = most significant field (hour).
  - field_add, out, NUM_FIELDS, single-cycle increment pulse for the selected field.
  - field_sub, out, NUM_FIELDS, single-cycle decrement pulse for the selected field.
  - adjusting, out, 1, high while any field is selected.

Function
REQ-003 FSM states SHALL be RUN, ADJ_IDLE, ADJ_DELAY, ADJ_REPEAT; field index fidx runs 0..NUM_FIELDS-1.
REQ-004 RUN + key_adjust_flag SHALL go to ADJ_IDLE with fidx=0.
REQ-005 In any ADJ_* state, key_adjust_flag SHALL do one of the following:
  - fidx<NUM_FIELDS-1: increment fidx and go to ADJ_IDLE.
  - fidx=NUM_FIELDS-1: go to RUN.
REQ-006 field_en SHALL equal 1<<(NUM_FIELDS-1-fidx) in ADJ_* and 0 in RUN; adjusting SHALL equal |field_en.
REQ-007 In ADJ_IDLE, key_add_flag (or key_sub_flag) SHALL do both:
  - pulse field_add (or field_sub) on the field_en bit for exactly one cycle, registered, asserted the cycle after the flag.
  - go to ADJ_DELAY.
REQ-008 ADJ_DELAY SHALL count REPEAT_DLY cycles while the matching hold stays high, then go to ADJ_REPEAT; hold low SHALL return to ADJ_IDLE with no pulse.
REQ-009 ADJ_REPEAT SHALL emit one pulse of the latched direction every REPEAT_PER cycles, the first REPEAT_PER cycles after entry, while hold stays high; hold low SHALL return to ADJ_IDLE.
REQ-010 Direction SHALL be latched at the initiating flag; the opposite hold/flag SHALL be ignored until return to ADJ_IDLE.
REQ-011 Simultaneous events SHALL resolve as follows:
  - key_add_flag and key_sub_flag together: both ignored.
  - key_adjust_flag with add/sub: adjust wins, add/sub dropped, any repeat cancelled.
REQ-012 field_add and field_sub SHALL never both be nonzero, SHALL be zero in RUN, and SHALL be at most one-hot.
REQ-013 The timeout counter SHALL clear on any key flag or while any hold is high.
REQ-014 Reaching TIMEOUT idle cycles in an ADJ_* state SHALL force RUN the next cycle with no pulse.
REQ-015 Counter widths SHALL be $clog2(max parameter+1); counters SHALL saturate, never wrap.
REQ-016 Key flags in RUN other than key_adjust_flag, and holds in RUN, SHALL have no effect.

Reset
REQ-017 sys_rst high at a rising edge SHALL force the following, overriding all inputs in that cycle:
  - state RUN, fidx 0, all counters 0.
  - field_en, field_add, field_sub, adjusting = 0.
REQ-018 Reset mid-repeat SHALL produce no pulse in or after the reset cycle; the first edge with sys_rst low SHALL evaluate inputs normally.

Structure
REQ-019 Package time_adj_pkg SHALL hold the state enum and the default REPEAT_DLY, REPEAT_PER and TIMEOUT constants.
REQ-020 Sub-module key_repeat_timer SHALL hold the delay/period counting:
  - inputs: start, hold, params.
  - output: tick.
  - instantiated once.

Verification
All scenarios SHALL use NUM_FIELDS=3, REPEAT_DLY=8, REPEAT_PER=4, TIMEOUT=32.
REQ-021 Mode cycling: adjust pulses x4 -> field_en 100, 010, 001, 000; adjusting 1,1,1,0.
REQ-022 Single add: in field 1, add flag with hold low -> field_add=010 for exactly one cycle, one cycle after the flag; field_sub stays 000.
REQ-023 Auto-repeat: in field 0, sub flag then hold for 30 cycles -> pulses at offsets +1, +13, +17, +21, +25, +29; release -> no further pulses.
REQ-024 Timeout: in field 2, no keys for 32 cycles -> RUN, field_en=000; any key activity at cycle 31 restarts the count.
REQ-025 Conflicts: add and sub together -> no pulse; adjust and add together in field 0 -> field_en=010, no add pulse.
REQ-026 Reset mid-repeat: sys_rst during ADJ_REPEAT -> all outputs 0 that cycle, state RUN, no pulse after release.
